// File: rtl/lbist_if.sv
// lbist_if: control/observe bundle between the LBIST sequencer and the mid section.
interface lbist_if #(
  parameter int OUT_BITS = 2,
  parameter int FW = 8
);
  logic                start;
  logic [OUT_BITS-1:0] CUT_OP;
  logic [OUT_BITS-1:0] FF_OP;
  logic                PAT_RST;
  logic                PAT_STEP;
  logic                FIL_INC;
  logic                busy;
  logic                done;
  logic [FW-1:0]       FAULT_IDX;
  logic                DET_VALID;
  logic                DET_FLAG;
  logic [FW-1:0]       DET_CNT;
  modport master (
    input  start, CUT_OP, FF_OP,
    output PAT_RST, PAT_STEP, FIL_INC, busy, done, FAULT_IDX, DET_VALID, DET_FLAG, DET_CNT
  );
  modport slave (
    output start, CUT_OP, FF_OP,
    input  PAT_RST, PAT_STEP, FIL_INC, busy, done, FAULT_IDX, DET_VALID, DET_FLAG, DET_CNT
  );
endinterface

// File: rtl/lbist_ctrl.sv
// lbist_ctrl: walks every injectable fault, applies patterns until first mismatch and counts detections.
module lbist_ctrl #(
  parameter int OUT_BITS = 2,
  parameter int NUM_FAULTS = 22,
  parameter int PAT_PER_FAULT = 32,
  parameter int FW = 8,
  parameter int PW = 6
) (
  input logic     clk,
  input logic     rst,
  lbist_if.master bus
);
  typedef enum logic [2:0] {IDLE, SEED, APPLY, RECORD, NEXT, SETTLE, DONE} state_t;
  state_t state;
  logic [PW-1:0] cnt;
  logic [OUT_BITS-1:0] diff;
  logic det, mis, last;
  assign diff = bus.CUT_OP ^ bus.FF_OP;
  assign mis = |diff;
  assign last = cnt == PW'(PAT_PER_FAULT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      det           <= 1'b0;
      bus.PAT_RST   <= 1'b0;
      bus.PAT_STEP  <= 1'b0;
      bus.FIL_INC   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.FAULT_IDX <= '0;
      bus.DET_VALID <= 1'b0;
      bus.DET_FLAG  <= 1'b0;
      bus.DET_CNT   <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state         <= SEED;
          bus.PAT_RST   <= 1'b1;
          bus.busy      <= 1'b1;
          bus.done      <= 1'b0;
          bus.FAULT_IDX <= '0;
          bus.DET_CNT   <= '0;
        end
        SEED: begin
          state        <= APPLY;
          cnt          <= '0;
          bus.PAT_RST  <= 1'b0;
          bus.PAT_STEP <= 1'b1;
        end
        // first mismatch drops the fault; the last pattern still gets compared
        APPLY: begin
          cnt <= cnt + 1'b1;
          if (mis || last) begin
            state         <= RECORD;
            det           <= mis;
            bus.PAT_STEP  <= 1'b0;
            bus.DET_VALID <= 1'b1;
            bus.DET_FLAG  <= mis;
          end
        end
        RECORD: begin
          state         <= NEXT;
          bus.DET_VALID <= 1'b0;
          bus.DET_FLAG  <= 1'b0;
          bus.FIL_INC   <= 1'b1;
          bus.DET_CNT   <= bus.DET_CNT + FW'(det && !(&bus.DET_CNT));
        end
        NEXT: begin
          det         <= 1'b0;
          bus.FIL_INC <= 1'b0;
          if (bus.FAULT_IDX == FW'(NUM_FAULTS - 1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state         <= SETTLE;
            bus.FAULT_IDX <= bus.FAULT_IDX + 1'b1;
          end
        end
        SETTLE: begin
          state       <= SEED;
          bus.PAT_RST <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
